// File: rtl/phase_gen_pkg.sv
// Shared types and constants for the multi-channel phase generator.
package phase_gen_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_NOISE  = 2'd3
    } wave_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Octave-0 step for a 20-bit accumulator at 48 kHz; notes 12-15 are silent.
    function automatic logic [19:0] base_step(input logic [3:0] note);
        logic [19:0] s;
        case (note)
            4'd0:    s = 20'd357;
            4'd1:    s = 20'd378;
            4'd2:    s = 20'd401;
            4'd3:    s = 20'd425;
            4'd4:    s = 20'd450;
            4'd5:    s = 20'd477;
            4'd6:    s = 20'd505;
            4'd7:    s = 20'd535;
            4'd8:    s = 20'd567;
            4'd9:    s = 20'd601;
            4'd10:   s = 20'd636;
            4'd11:   s = 20'd674;
            default: s = 20'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/phase_gen_mc_wave_shaper.sv
// Combinational waveform generator: phase accumulator value plus wave select -> signed sample.
module wave_shaper
    import phase_gen_pkg::*;
#(
    parameter int PHASE_W = 20,
    parameter int OUT_W   = 16
) (
    input  logic [PHASE_W-1:0] phase,
    input  logic [1:0]         wave,
    input  logic [15:0]        noise,
    output logic [OUT_W-1:0]   sample
);

    localparam logic [OUT_W-1:0] MSB_MASK = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SQ_POS   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SQ_NEG   = ~SQ_POS + OUT_W'(1);

    logic [PHASE_W:0]   phase_x;
    logic [OUT_W-1:0]   t, u, tri_v, noise_v;
    logic               p_msb;
    logic               in_unused;

    assign phase_x   = {phase, 1'b0};
    assign t         = phase[PHASE_W-1 -: OUT_W];
    // One bit below t; the padded copy keeps the slice legal when OUT_W equals PHASE_W.
    assign u         = phase_x[PHASE_W-1 -: OUT_W];
    assign p_msb     = phase[PHASE_W-1];
    assign tri_v     = p_msb ? ~u : u;
    assign in_unused = ^{phase, noise};

    generate
        if (OUT_W >= 16) begin : g_noise_ext
            assign noise_v = OUT_W'($signed(noise));
        end else begin : g_noise_trunc
            assign noise_v = noise[15 -: OUT_W];
        end
    endgenerate

    always_comb begin
        sample = '0;
        case (wave)
            WAVE_SAW:    sample = t ^ MSB_MASK;
            WAVE_SQUARE: sample = p_msb ? SQ_NEG : SQ_POS;
            WAVE_TRI:    sample = tri_v ^ MSB_MASK;
            WAVE_NOISE:  sample = noise_v;
            default:     sample = '0;
        endcase
    end

endmodule

// File: rtl/phase_gen_mc.sv
// Time-multiplexed multi-channel phase generator; one sample per channel per sample_en frame.
// Optional `define NOISE_EN enables the LFSR noise source on wave 3 (otherwise wave 3 is silent).
module phase_gen_mc
    import phase_gen_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int PHASE_W = 20,
    parameter int OUT_W   = 16,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             phiM,
    input  logic             IC_b,
    input  logic             sample_en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [7:0]       cfg_key_code,
    input  logic [1:0]       cfg_wave,
    input  logic             cfg_key_on,
    output logic [OUT_W-1:0] out_val,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_valid,
    output logic             frame_done,
    output logic             overrun
);

    logic [PHASE_W-1:0] phase   [NUM_CH];
    logic [6:0]         key_code[NUM_CH];
    wave_e              wave_q  [NUM_CH];
    logic [NUM_CH-1:0]  key_on;

    state_e             state, state_nxt;
    logic [CH_W-1:0]    ch_idx, ch_idx_nxt;
    logic               running, last_ch;

    logic [PHASE_W-1:0] cur_phase, step;
    logic [6:0]         cur_kc;
    wave_e              cur_wave;
    logic               cur_on;
    logic [15:0]        noise_val;
    logic [OUT_W-1:0]   shaped, sample;
    logic               kc_unused;

    assign kc_unused = cfg_key_code[7];
    assign running   = (state == ST_RUN);
    assign last_ch   = (ch_idx == CH_W'(NUM_CH - 1));

    always_ff @(posedge phiM or negedge IC_b) begin
        if (!IC_b) begin
            state  <= ST_IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_nxt;
            ch_idx <= ch_idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_idx_nxt = ch_idx;
        case (state)
            ST_IDLE: begin
                if (sample_en) begin
                    state_nxt  = ST_RUN;
                    ch_idx_nxt = '0;
                end
            end
            ST_RUN: begin
                if (last_ch) begin
                    state_nxt  = ST_IDLE;
                    ch_idx_nxt = '0;
                end else begin
                    ch_idx_nxt = ch_idx + 1'b1;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                ch_idx_nxt = '0;
            end
        endcase
    end

    assign cur_phase = phase[ch_idx];
    assign cur_kc    = key_code[ch_idx];
    assign cur_wave  = wave_q[ch_idx];
    assign cur_on    = key_on[ch_idx];

    always_comb begin
        step = PHASE_W'(base_step(cur_kc[3:0])) << cur_kc[6:4];
        step = step << (PHASE_W - 20);
    end

    wave_shaper #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_wave_shaper (
        .phase  (cur_phase),
        .wave   (cur_wave),
        .noise  (noise_val),
        .sample (shaped)
    );

    assign sample = cur_on ? shaped : '0;

    // The config write comes after the phase update so a key-on retrigger wins;
    // other fields only affect the channel from its next RUN slot onward.
    always_ff @(posedge phiM or negedge IC_b) begin
        if (!IC_b) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                phase[i]    <= '0;
                key_code[i] <= '0;
                wave_q[i]   <= WAVE_SAW;
            end
            key_on <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (running && ch_idx == CH_W'(i) && key_on[i])
                    phase[i] <= phase[i] + step;
                if (cfg_we && cfg_ch == CH_W'(i)) begin
                    key_code[i] <= cfg_key_code[6:0];
                    wave_q[i]   <= wave_e'(cfg_wave);
                    key_on[i]   <= cfg_key_on;
                    if (cfg_key_on && !key_on[i])
                        phase[i] <= '0;
                end
            end
        end
    end

`ifdef NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge phiM or negedge IC_b) begin
        if (!IC_b)
            lfsr <= LFSR_SEED;
        else if (running && cur_on && cur_wave == WAVE_NOISE)
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    assign noise_val = lfsr;
`else
    assign noise_val = '0;
`endif

    always_ff @(posedge phiM or negedge IC_b) begin
        if (!IC_b) begin
            out_val    <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid  <= running;
            frame_done <= running && last_ch;
            if (running) begin
                out_val <= sample;
                out_ch  <= ch_idx;
            end
            if (running && sample_en)
                overrun <= 1'b1;
        end
    end

endmodule
